// File: rtl/aximm_pkg.sv
// Shared AXI encodings and FSM state types for the buffer-RAM AXI master.
package aximm_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IB_IDLE,
        IB_AW_W,
        IB_WAIT_B
    } ibState_e;

    typedef enum logic [1:0] {
        OB_IDLE,
        OB_AR,
        OB_RDATA,
        OB_DONE
    } obState_e;

endpackage

// File: rtl/aximm_rd_prefetch.sv
// Two-entry skid FIFO in front of a 1-cycle-latency RAM read port.
// Reads addresses 0..len once per start and presents them as a valid/ready
// stream; keeps occupancy plus in-flight reads at or below two so a beat
// is never dropped when the consumer stalls.
module aximm_rd_prefetch
    import aximm_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int RAM_AW = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        len,
    output logic              ramRdEn,
    output logic [RAM_AW-1:0] ramRdAddr,
    input  logic [DATA_W-1:0] ramRdData,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    input  logic              outReady
);

    logic [7:0]        lenQ;
    logic [8:0]        issueCnt;
    logic [8:0]        popCnt;
    logic              busy;
    logic              inflight;
    logic [1:0]        count;
    logic              wrPtr;
    logic              rdPtr;
    logic [DATA_W-1:0] mem [2];
    logic              pop;
    logic [2:0]        occAfter;

    assign outValid  = (count != 2'd0);
    assign outData   = mem[rdPtr];
    assign outLast   = outValid && (popCnt == {1'b0, lenQ});
    assign pop       = outValid && outReady;
    assign occAfter  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign ramRdEn   = busy && (issueCnt <= {1'b0, lenQ}) && (occAfter < 3'd2);
    assign ramRdAddr = RAM_AW'(issueCnt);

    // Read issue, in-flight tracking and FIFO pointer/occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lenQ     <= '0;
            issueCnt <= '0;
            popCnt   <= '0;
            busy     <= 1'b0;
            inflight <= 1'b0;
            count    <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
        end else if (start) begin
            lenQ     <= len;
            issueCnt <= '0;
            popCnt   <= '0;
            busy     <= 1'b1;
            inflight <= 1'b0;
            count    <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
        end else begin
            inflight <= ramRdEn;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (ramRdEn) begin
                issueCnt <= issueCnt + 9'd1;
            end
            if (inflight) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr  <= ~rdPtr;
                popCnt <= popCnt + 9'd1;
                if (outLast) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // Capture RAM read data the cycle after each read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (inflight) begin
            mem[wrPtr] <= ramRdData;
        end
    end

endmodule

// File: rtl/aximm_buf_master.sv
// AXI4 master between the DMA buffer RAMs and the interconnect.
// Inbound: drains the inbound RAM as one INCR write burst, then frees it.
// Outbound: fills the outbound RAM from one INCR read burst, then signals done.
// The two directions share nothing and may run at the same time.
module aximm_buf_master
    import aximm_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128,
    parameter int RAM_AW = 8
)
(
    input  logic                clk,
    input  logic                rst_n,
    // inbound buffer side
    input  logic                ib_data_valid,
    output logic                ib_ram_valid,
    input  logic [ADDR_W-1:0]   ib_axi_addr,
    input  logic [7:0]          ib_len,
    output logic                ib_ram_rd_en,
    output logic [RAM_AW-1:0]   ib_ram_rd_addr,
    input  logic [DATA_W-1:0]   ib_ram_rd_data,
    output logic                ib_err,
    // outbound buffer side
    input  logic                ob_req_valid,
    output logic                ob_req_ready,
    input  logic [ADDR_W-1:0]   ob_axi_addr,
    input  logic [7:0]          ob_len,
    input  logic                ob_ram_valid,
    output logic                ob_data_valid,
    output logic                ob_ram_wr_en,
    output logic [RAM_AW-1:0]   ob_ram_wr_addr,
    output logic [DATA_W-1:0]   ob_ram_wr_data,
    output logic                ob_err,
    // AXI write channels
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    // AXI read channels
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_W / 8));

    // ---------------- inbound (AXI write) ----------------
    ibState_e          ibState;
    ibState_e          ibNext;
    logic [ADDR_W-1:0] ibAddrQ;
    logic [7:0]        ibLenQ;
    logic              awDone;
    logic              wDone;
    logic              ibErrQ;
    logic              ibStart;
    logic              pfValid;
    logic              pfLast;
    logic [DATA_W-1:0] pfData;
    logic              wHs;

    assign ibStart   = (ibState == IB_IDLE) && ib_data_valid;
    assign wHs       = pfValid && m_wready;
    assign m_awaddr  = ibAddrQ;
    assign m_awlen   = ibLenQ;
    assign m_awsize  = AXI_SIZE;
    assign m_awburst = BURST_INCR;
    assign m_wvalid  = pfValid;
    assign m_wdata   = pfData;
    assign m_wstrb   = '1;
    assign m_wlast   = pfLast;
    assign ib_err    = ibErrQ;

    aximm_rd_prefetch #(
        .DATA_W (DATA_W),
        .RAM_AW (RAM_AW)
    ) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (ibStart),
        .len       (ib_len),
        .ramRdEn   (ib_ram_rd_en),
        .ramRdAddr (ib_ram_rd_addr),
        .ramRdData (ib_ram_rd_data),
        .outValid  (pfValid),
        .outData   (pfData),
        .outLast   (pfLast),
        .outReady  (m_wready)
    );

    // Inbound state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibState <= IB_IDLE;
        end else begin
            ibState <= ibNext;
        end
    end

    // Inbound next state and channel handshake outputs.
    always_comb begin
        ibNext       = ibState;
        ib_ram_valid = 1'b0;
        m_awvalid    = 1'b0;
        m_bready     = 1'b0;
        case (ibState)
            IB_IDLE: begin
                ib_ram_valid = 1'b1;
                if (ib_data_valid) begin
                    ibNext = IB_AW_W;
                end
            end
            IB_AW_W: begin
                m_awvalid = !awDone;
                if ((awDone || m_awready) && (wDone || (wHs && pfLast))) begin
                    ibNext = IB_WAIT_B;
                end
            end
            IB_WAIT_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    ibNext = IB_IDLE;
                end
            end
            default: ibNext = IB_IDLE;
        endcase
    end

    // Latch burst parameters at start; track AW/W completion; time the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibAddrQ <= '0;
            ibLenQ  <= '0;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
            ibErrQ  <= 1'b0;
        end else begin
            ibErrQ <= (ibState == IB_WAIT_B) && m_bvalid && (m_bresp != RESP_OKAY);
            if (ibStart) begin
                ibAddrQ <= ib_axi_addr;
                ibLenQ  <= ib_len;
                awDone  <= 1'b0;
                wDone   <= 1'b0;
            end else begin
                if ((ibState == IB_AW_W) && !awDone && m_awready) begin
                    awDone <= 1'b1;
                end
                if (wHs && pfLast) begin
                    wDone <= 1'b1;
                end
            end
        end
    end

    // ---------------- outbound (AXI read) ----------------
    obState_e          obState;
    obState_e          obNext;
    logic [ADDR_W-1:0] obAddrQ;
    logic [7:0]        obLenQ;
    logic [7:0]        obBeat;
    logic              obErrAcc;
    logic              obAccept;
    logic              rHs;
    logic              lastBeat;

    assign obAccept  = (obState == OB_IDLE) && ob_ram_valid && ob_req_valid;
    assign rHs       = (obState == OB_RDATA) && m_rvalid;
    assign lastBeat  = (obBeat == obLenQ);
    assign m_araddr  = obAddrQ;
    assign m_arlen   = obLenQ;
    assign m_arsize  = AXI_SIZE;
    assign m_arburst = BURST_INCR;

    // Outbound state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obState <= OB_IDLE;
        end else begin
            obState <= obNext;
        end
    end

    // Outbound next state, request/AR/R handshakes and completion pulse.
    always_comb begin
        obNext        = obState;
        ob_req_ready  = 1'b0;
        m_arvalid     = 1'b0;
        m_rready      = 1'b0;
        ob_data_valid = 1'b0;
        ob_err        = 1'b0;
        case (obState)
            OB_IDLE: begin
                ob_req_ready = ob_ram_valid;
                if (ob_ram_valid && ob_req_valid) begin
                    obNext = OB_AR;
                end
            end
            OB_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    obNext = OB_RDATA;
                end
            end
            OB_RDATA: begin
                m_rready = 1'b1;
                if (m_rvalid && lastBeat) begin
                    obNext = OB_DONE;
                end
            end
            OB_DONE: begin
                ob_data_valid = 1'b1;
                ob_err        = obErrAcc;
                obNext        = OB_IDLE;
            end
            default: obNext = OB_IDLE;
        endcase
    end

    // Latch request, count beats, register RAM writes and collect errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obAddrQ        <= '0;
            obLenQ         <= '0;
            obBeat         <= '0;
            obErrAcc       <= 1'b0;
            ob_ram_wr_en   <= 1'b0;
            ob_ram_wr_addr <= '0;
            ob_ram_wr_data <= '0;
        end else begin
            ob_ram_wr_en <= rHs;
            if (obAccept) begin
                obAddrQ  <= ob_axi_addr;
                obLenQ   <= ob_len;
                obBeat   <= '0;
                obErrAcc <= 1'b0;
            end
            if (rHs) begin
                ob_ram_wr_addr <= RAM_AW'(obBeat);
                ob_ram_wr_data <= m_rdata;
                obBeat         <= obBeat + 8'd1;
                if ((m_rresp != RESP_OKAY) || (m_rlast != lastBeat)) begin
                    obErrAcc <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aximm_buf_master.sv
// Randomized directed bench for aximm_buf_master with behavioural RAM and AXI slave models.
module tb_aximm_buf_master;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 128;
    localparam int RAM_AW = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ib_data_valid = 1'b0;
    logic                ib_ram_valid;
    logic [ADDR_W-1:0]   ib_axi_addr = '0;
    logic [7:0]          ib_len = '0;
    logic                ib_ram_rd_en;
    logic [RAM_AW-1:0]   ib_ram_rd_addr;
    logic [DATA_W-1:0]   ib_ram_rd_data = '0;
    logic                ib_err;
    logic                ob_req_valid = 1'b0;
    logic                ob_req_ready;
    logic [ADDR_W-1:0]   ob_axi_addr = '0;
    logic [7:0]          ob_len = '0;
    logic                ob_ram_valid = 1'b0;
    logic                ob_data_valid;
    logic                ob_ram_wr_en;
    logic [RAM_AW-1:0]   ob_ram_wr_addr;
    logic [DATA_W-1:0]   ob_ram_wr_data;
    logic                ob_err;
    logic                m_awvalid;
    logic                m_awready = 1'b0;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_wvalid;
    logic                m_wready = 1'b0;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_bvalid = 1'b0;
    logic                m_bready;
    logic [1:0]          m_bresp = 2'b00;
    logic                m_arvalid;
    logic                m_arready = 1'b0;
    logic [ADDR_W-1:0]   m_araddr;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize;
    logic [1:0]          m_arburst;
    logic                m_rvalid = 1'b0;
    logic                m_rready;
    logic [DATA_W-1:0]   m_rdata = '0;
    logic [1:0]          m_rresp = 2'b00;
    logic                m_rlast = 1'b0;

    aximm_buf_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ib_data_valid(ib_data_valid), .ib_ram_valid(ib_ram_valid), .ib_axi_addr(ib_axi_addr),
        .ib_len(ib_len), .ib_ram_rd_en(ib_ram_rd_en), .ib_ram_rd_addr(ib_ram_rd_addr),
        .ib_ram_rd_data(ib_ram_rd_data), .ib_err(ib_err),
        .ob_req_valid(ob_req_valid), .ob_req_ready(ob_req_ready), .ob_axi_addr(ob_axi_addr),
        .ob_len(ob_len), .ob_ram_valid(ob_ram_valid), .ob_data_valid(ob_data_valid),
        .ob_ram_wr_en(ob_ram_wr_en), .ob_ram_wr_addr(ob_ram_wr_addr), .ob_ram_wr_data(ob_ram_wr_data),
        .ob_err(ob_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] ibRam  [256];
    logic [DATA_W-1:0] rBeats [256];

    logic [DATA_W-1:0] wQ[$];
    bit                wLastQ[$];
    int                wCycQ[$];
    int                obWrAddrQ[$];
    logic [DATA_W-1:0] obWrDataQ[$];
    int                awCnt, arCnt, dvCnt, dvWrCnt;
    logic              dvErr;
    logic [ADDR_W-1:0] awAddrCap, arAddrCap;
    logic [7:0]        awLenCap, arLenCap;
    logic [2:0]        awSizeCap, arSizeCap;
    logic [1:0]        awBurstCap, arBurstCap;
    int                stallBad, strbBad, ramValidBad, errStray;
    bit                ibTrack = 1'b0;
    bit                prevWStall = 1'b0;
    logic [DATA_W-1:0] prevWData;
    int                wrMode = 0;
    logic              rdEnS = 1'b0;
    logic [RAM_AW-1:0] rdAddrS = '0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clrMon();
        wQ.delete(); wLastQ.delete(); wCycQ.delete();
        obWrAddrQ.delete(); obWrDataQ.delete();
        awCnt = 0; arCnt = 0; dvCnt = 0; dvWrCnt = 0; dvErr = 1'b0;
        stallBad = 0; strbBad = 0; ramValidBad = 0; errStray = 0;
    endtask

    task automatic chkReset(input string pfx);
        chk({pfx, "_ib_ram_valid"}, ib_ram_valid, 1);
        chk({pfx, "_awvalid"}, m_awvalid, 0);
        chk({pfx, "_wvalid"}, m_wvalid, 0);
        chk({pfx, "_wlast"}, m_wlast, 0);
        chk({pfx, "_bready"}, m_bready, 0);
        chk({pfx, "_rd_en"}, ib_ram_rd_en, 0);
        chk({pfx, "_rd_addr"}, ib_ram_rd_addr, 0);
        chk({pfx, "_awaddr"}, m_awaddr, 0);
        chk({pfx, "_ib_err"}, ib_err, 0);
        chk({pfx, "_arvalid"}, m_arvalid, 0);
        chk({pfx, "_rready"}, m_rready, 0);
        chk({pfx, "_ob_data_valid"}, ob_data_valid, 0);
        chk({pfx, "_ob_err"}, ob_err, 0);
        chk({pfx, "_wr_en"}, ob_ram_wr_en, 0);
        chk({pfx, "_wr_addr"}, ob_ram_wr_addr, 0);
    endtask

    // Cycle counter for beat spacing.
    always @(posedge clk) cyc++;

    // Inbound RAM: read data appears the cycle after the strobe.
    always @(negedge clk) begin
        rdEnS   = ib_ram_rd_en;
        rdAddrS = ib_ram_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        if (rdEnS) ib_ram_rd_data = ibRam[rdAddrS];
    end

    // Slave ready generators.
    always @(posedge clk) begin
        #1;
        m_awready = 1'($urandom_range(0, 1));
        m_arready = 1'($urandom_range(0, 1));
        case (wrMode)
            0:       m_wready = 1'b1;
            1:       m_wready = ~m_wready;
            default: m_wready = 1'($urandom_range(0, 1));
        endcase
    end

    // Channel monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevWStall = 1'b0;
        end else begin
            if (prevWStall && (!m_wvalid || (m_wdata !== prevWData))) stallBad++;
            prevWStall = m_wvalid && !m_wready;
            prevWData  = m_wdata;
            if (m_wvalid && m_wready) begin
                wQ.push_back(m_wdata);
                wLastQ.push_back(m_wlast);
                wCycQ.push_back(cyc);
                if (m_wstrb !== '1) strbBad++;
            end
            if (m_awvalid && m_awready) begin
                awCnt++;
                awAddrCap = m_awaddr; awLenCap = m_awlen; awSizeCap = m_awsize; awBurstCap = m_awburst;
            end
            if (m_arvalid && m_arready) begin
                arCnt++;
                arAddrCap = m_araddr; arLenCap = m_arlen; arSizeCap = m_arsize; arBurstCap = m_arburst;
            end
            if (ob_ram_wr_en) begin
                obWrAddrQ.push_back(int'(ob_ram_wr_addr));
                obWrDataQ.push_back(ob_ram_wr_data);
            end
            if (ob_data_valid) begin
                dvCnt++;
                dvErr   = ob_err;
                dvWrCnt = obWrAddrQ.size();
            end
            if (ob_err && !ob_data_valid) errStray++;
            if (ibTrack && ib_ram_valid) ramValidBad++;
        end
    end

    task automatic ibBurst(input int len, input int mode, input logic [1:0] bresp);
        int n;
        logic [ADDR_W-1:0] addr;
        for (int i = 0; i < 256; i++) ibRam[i] = {$urandom, $urandom, $urandom, $urandom};
        addr = {$urandom, $urandom & 32'hFFFF_F000};
        clrMon();
        wrMode = mode;
        @(posedge clk); #1;
        ib_axi_addr = addr; ib_len = 8'(len); ib_data_valid = 1'b1;
        @(negedge clk);
        chk("ib_ram_valid_idle", ib_ram_valid, 1);
        @(posedge clk); #1;
        ib_data_valid = 1'b0;
        ib_axi_addr = {$urandom, $urandom}; ib_len = 8'($urandom);
        @(negedge clk);
        chk("ib_ram_valid_drop", ib_ram_valid, 0);
        ibTrack = 1'b1;
        n = 0;
        while (!(wQ.size() == len + 1 && awCnt == 1) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("ib_burst_in_time", n < 2000, 1);
        @(posedge clk); #1;
        m_bvalid = 1'b1; m_bresp = bresp;
        n = 0;
        @(negedge clk);
        while (!m_bready && n < 50) begin
            @(negedge clk); n++;
        end
        chk("ib_bready", m_bready, 1);
        chk("ib_ram_valid_at_b", ib_ram_valid, 0);
        @(posedge clk); #1;
        m_bvalid = 1'b0; m_bresp = 2'b00; ibTrack = 1'b0;
        @(negedge clk);
        chk("ib_ram_valid_after_b", ib_ram_valid, 1);
        chk("ib_err_pulse", ib_err, (bresp != 2'b00));
        @(negedge clk);
        chk("ib_err_one_cycle", ib_err, 0);
        chk("ib_no_retrigger", ib_ram_valid, 1);
        chk("ib_beat_count", wQ.size(), len + 1);
        for (int i = 0; i < wQ.size(); i++) begin
            chk($sformatf("ib_wdata[%0d]", i), wQ[i], ibRam[i]);
            chk($sformatf("ib_wlast[%0d]", i), wLastQ[i], (i == len));
        end
        chk("ib_awaddr", awAddrCap, addr);
        chk("ib_awlen", awLenCap, len);
        chk("ib_awsize", awSizeCap, 4);
        chk("ib_awburst", awBurstCap, 1);
        chk("ib_wstrb", strbBad, 0);
        chk("ib_w_stable", stallBad, 0);
        chk("ib_ram_valid_low", ramValidBad, 0);
        if (mode == 0 && wCycQ.size() == len + 1) chk("ib_back_to_back", wCycQ[len] - wCycQ[0], len);
    endtask

    task automatic obBurst(input int len, input int rlastBeat, input int errBeat, input bit gaps);
        int n;
        int rTimeout;
        logic [ADDR_W-1:0] addr;
        bit expErr;
        for (int i = 0; i <= len; i++) rBeats[i] = {$urandom, $urandom, $urandom, $urandom};
        addr = {$urandom, $urandom & 32'hFFFF_F000};
        expErr = (rlastBeat != len) || (errBeat >= 0 && errBeat <= len);
        clrMon();
        rTimeout = 0;
        @(posedge clk); #1;
        ob_axi_addr = addr; ob_len = 8'(len); ob_req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ob_req_ready_blocked", ob_req_ready, 0);
        end
        chk("ob_no_ar_blocked", m_arvalid, 0);
        @(posedge clk); #1;
        ob_ram_valid = 1'b1;
        @(negedge clk);
        chk("ob_req_ready_open", ob_req_ready, 1);
        @(posedge clk); #1;
        ob_req_valid = 1'b0; ob_axi_addr = {$urandom, $urandom}; ob_len = 8'($urandom);
        n = 0;
        while (arCnt == 0 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("ob_ar_in_time", n < 50, 1);
        for (int i = 0; i <= len; i++) begin
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 1) == 1) begin
                m_rvalid = 1'b0;
                @(posedge clk); #1;
            end
            m_rvalid = 1'b1; m_rdata = rBeats[i];
            m_rlast = (i == rlastBeat);
            m_rresp = (i == errBeat) ? 2'b10 : 2'b00;
            n = 0;
            @(negedge clk);
            while (!m_rready && n < 50) begin
                @(negedge clk); n++;
            end
            if (n >= 50) rTimeout++;
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        chk("ob_r_timeouts", rTimeout, 0);
        n = 0;
        while (dvCnt == 0 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("ob_done_in_time", n < 50, 1);
        @(posedge clk); #1;
        ob_ram_valid = 1'b0;
        @(negedge clk);
        chk("ob_dv_one_cycle", ob_data_valid, 0);
        chk("ob_req_ready_after", ob_req_ready, 0);
        chk("ob_dv_count", dvCnt, 1);
        chk("ob_writes_at_dv", dvWrCnt, len + 1);
        chk("ob_err", dvErr, expErr);
        chk("ob_err_stray", errStray, 0);
        chk("ob_write_count", obWrAddrQ.size(), len + 1);
        for (int i = 0; i < obWrAddrQ.size(); i++) begin
            chk($sformatf("ob_wr_addr[%0d]", i), obWrAddrQ[i], i);
            chk($sformatf("ob_wr_data[%0d]", i), obWrDataQ[i], rBeats[i]);
        end
        chk("ob_araddr", arAddrCap, addr);
        chk("ob_arlen", arLenCap, len);
        chk("ob_arsize", arSizeCap, 4);
        chk("ob_arburst", arBurstCap, 1);
        chk("ob_ar_count", arCnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrMon();
        #2;
        chkReset("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        ibBurst(3, 0, 2'b00);
        ibBurst(7, 1, 2'b00);
        ibBurst(10, 2, 2'b10);
        ibBurst(0, 2, 2'b00);

        obBurst(15, 15, -1, 1'b0);
        obBurst(7, 5, -1, 1'b0);
        obBurst(9, 9, 4, 1'b1);
        obBurst(0, 0, -1, 1'b1);

        // Reset in the middle of a W burst, then a clean burst.
        clrMon();
        wrMode = 0;
        for (int i = 0; i < 256; i++) ibRam[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        ib_axi_addr = 64'h1000; ib_len = 8'd15; ib_data_valid = 1'b1;
        @(posedge clk); #1;
        ib_data_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_burst_active", ib_ram_valid, 0);
        chk("rst_beats_started", (wQ.size() > 0) && (wQ.size() < 16), 1);
        #1 rst_n = 1'b0;
        #1;
        chkReset("mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        ibBurst(5, 2, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
